lsu_bram_master: RTL and testbench

- Data-side load/store unit; initiator for the BRAM data port (port B: registered read, 1-cycle latency, byte-lane write enables, big-endian, 16-bit words).
- Accepts one CPU memory request at a time via valid/ready, drives the BRAM port, and returns one response per request.
- Performs lane steering, sign/zero extension and alignment checking.
- Sits between the core's execute stage and the 1 KiB data memory.

---
 rtl/lsu_bram_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu_bram_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bram_master.sv
// Data-side load/store unit driving a 16-bit big-endian BRAM port (1-cycle read latency).
// Optional macro LSU_MISALIGN_SPLIT_EN: split misaligned word accesses into two BRAM accesses.
module lsu_bram_master #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WR_RSP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              m_en,
  output logic              m_we_h,
  output logic              m_we_l,
  output logic [ADDR_W-2:0] m_addr,
  output logic [7:0]        m_din_h,
  output logic [7:0]        m_din_l,
  input  logic [7:0]        m_dout_h,
  input  logic [7:0]        m_dout_l
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    ISSUE2 = 3'd4,
    WAIT2  = 3'd5
`endif
  } state_e;

  state_e state_q, state_d;
  logic we_q, we_d, size_q, size_d, sgn_q, sgn_d, lsb_q, lsb_d;
  logic m_en_q, m_en_d, m_we_h_q, m_we_h_d, m_we_l_q, m_we_l_d;
  logic [ADDR_W-2:0] m_addr_q, m_addr_d;
  logic [7:0] m_din_h_q, m_din_h_d, m_din_l_q, m_din_l_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0] bsel;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [7:0] wlo_q, wlo_d, hi_q, hi_d;
  assign addr_inc = addr_q + ADDR_W'(1);
`endif

  // Next state, next registered outputs
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lsb_d       = lsb_q;
    m_en_d      = 1'b0;
    m_we_h_d    = 1'b0;
    m_we_l_d    = 1'b0;
    m_addr_d    = '0;
    m_din_h_d   = 8'h00;
    m_din_l_d   = 8'h00;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    bsel        = lsb_q ? m_dout_l : m_dout_h;
`ifdef LSU_MISALIGN_SPLIT_EN
    addr_d      = addr_q;
    wlo_d       = wlo_q;
    hi_d        = hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          sgn_d  = req_signed;
          lsb_d  = req_addr[0];
`ifdef LSU_MISALIGN_SPLIT_EN
          addr_d = req_addr;
          wlo_d  = req_wdata[7:0];
`else
          if (req_size && req_addr[0]) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 16'h0000;
          end else
`endif
          begin
            state_d  = ISSUE;
            m_en_d   = 1'b1;
            m_addr_d = req_addr[ADDR_W-1:1];
            if (req_we) begin
              if (req_size) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (req_addr[0]) begin
                  m_we_l_d  = 1'b1;
                  m_din_l_d = req_wdata[15:8];
                end else
`endif
                begin
                  m_we_h_d  = 1'b1;
                  m_we_l_d  = 1'b1;
                  m_din_h_d = req_wdata[15:8];
                  m_din_l_d = req_wdata[7:0];
                end
              end else if (req_addr[0]) begin
                m_we_l_d  = 1'b1;
                m_din_l_d = req_wdata[7:0];
              end else begin
                m_we_h_d  = 1'b1;
                m_din_h_d = req_wdata[7:0];
              end
            end
          end
        end
      end
      ISSUE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        // Second half of a split word goes to the high lane of the next word
        if (size_q && lsb_q) begin
          state_d  = ISSUE2;
          m_en_d   = 1'b1;
          m_addr_d = addr_inc[ADDR_W-1:1];
          if (we_q) begin
            m_we_h_d  = 1'b1;
            m_din_h_d = wlo_q;
          end
        end else
`endif
        if (we_q) begin
          if (WR_RSP != 0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 16'h0000;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = size_q ? {m_dout_h, m_dout_l} : {{8{sgn_q & bsel[7]}}, bsel};
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE2: begin
        if (we_q) begin
          if (WR_RSP != 0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 16'h0000;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hi_d    = m_dout_l;
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {hi_q, m_dout_h};
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      sgn_q       <= 1'b0;
      lsb_q       <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_h_q    <= 1'b0;
      m_we_l_q    <= 1'b0;
      m_addr_q    <= '0;
      m_din_h_q   <= 8'h00;
      m_din_l_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q      <= '0;
      wlo_q       <= 8'h00;
      hi_q        <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lsb_q       <= lsb_d;
      m_en_q      <= m_en_d;
      m_we_h_q    <= m_we_h_d;
      m_we_l_q    <= m_we_l_d;
      m_addr_q    <= m_addr_d;
      m_din_h_q   <= m_din_h_d;
      m_din_l_q   <= m_din_l_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q      <= addr_d;
      wlo_q       <= wlo_d;
      hi_q        <= hi_d;
`endif
    end
  end

  // Gating enables with rst keeps a write in flight from landing when reset hits ISSUE
  assign req_ready = (state_q == IDLE) && !rst;
  assign m_en      = m_en_q & ~rst;
  assign m_we_h    = m_we_h_q & ~rst;
  assign m_we_l    = m_we_l_q & ~rst;
  assign m_addr    = m_addr_q;
  assign m_din_h   = m_din_h_q;
  assign m_din_l   = m_din_l_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_bram_master.sv
// Scoreboard bench for lsu_bram_master with a behavioural BRAM port-B model.
module tb_lsu_bram_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_size = 1'b0, req_signed = 1'b0;
  logic [9:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic rsp_valid, rsp_err, m_en, m_we_h, m_we_l;
  logic [15:0] rsp_rdata;
  logic [8:0] m_addr;
  logic [7:0] m_din_h, m_din_l, m_dout_h, m_dout_l;

  always #5 clk = ~clk;

  lsu_bram_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_en(m_en), .m_we_h(m_we_h), .m_we_l(m_we_l), .m_addr(m_addr),
    .m_din_h(m_din_h), .m_din_l(m_din_l), .m_dout_h(m_dout_h), .m_dout_l(m_dout_l)
  );

  // Registered-read BRAM, read-before-write
  logic [7:0] mem_h [512];
  logic [7:0] mem_l [512];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we_h) mem_h[m_addr] <= m_din_h;
      if (m_we_l) mem_l[m_addr] <= m_din_l;
      m_dout_h <= mem_h[m_addr];
      m_dout_l <= mem_l[m_addr];
    end
  end

  typedef struct packed { logic [15:0] d; logic e; int c; } rsp_t;
  typedef struct packed { logic [8:0] a; logic wh; logic wl; logic [7:0] dh; logic [7:0] dl; } acc_t;

  rsp_t exp_q[$];
  rsp_t act_q[$];
  acc_t en_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) act_q.push_back('{rsp_rdata, rsp_err, cyc});
    if (m_en) en_q.push_back('{m_addr, m_we_h, m_we_l, m_din_h, m_din_l});
  end

  task automatic send(input logic we, input logic sz, input logic sg, input logic [9:0] ad,
                      input logic [15:0] wd, input bit keep, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc >= 0) @(negedge clk);
    if (!keep) req_valid = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout addr=%h got no accept want accept within 40 cycles", ad);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && act_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %b want 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, m_en, m_we_h, m_we_l} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {rsp_valid, rsp_err, m_en, m_we_h, m_we_l});
    end
    checks++;
    if ({rsp_rdata, m_addr, m_din_h, m_din_l} !== 41'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {rsp_rdata, m_addr, m_din_h, m_din_l});
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_word();
    int acc;
    rsp_t e, a;
    acc_t w;
    send(1'b1, 1'b1, 1'b0, 10'h010, 16'hBEEF, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 1});
    wait_rsp(1);
    w = '{9'h008, 1'b1, 1'b1, 8'hBE, 8'hEF};
    checks++;
    if (en_q.size() != 1 || en_q[0] !== w) begin
      errors++; $display("FAIL word_store_port got n=%0d %h want n=1 %h", en_q.size(), en_q[0], w);
    end
    en_q.delete();
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'hBEEF, 1'b0, acc + 2});
    wait_rsp(2);
    w = '{9'h008, 1'b0, 1'b0, 8'h00, 8'h00};
    checks++;
    if (en_q.size() != 1 || en_q[0] !== w) begin
      errors++; $display("FAIL word_load_port got n=%0d %h want n=1 %h", en_q.size(), en_q[0], w);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL word_rsp_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL word_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_byte_load();
    int acc;
    rsp_t e, a;
    logic [9:0] ad [4] = '{10'h010, 10'h011, 10'h011, 10'h010};
    logic sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ex [4] = '{16'hFFBE, 16'h00EF, 16'hFFEF, 16'h00BE};
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b0, sg[i], ad[i], 16'h0000, 1'b0, acc);
      exp_q.push_back('{ex[i], 1'b0, acc + 2});
    end
    wait_rsp(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL byte_load_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL byte_load got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_byte_store();
    int acc;
    rsp_t e, a;
    acc_t w;
    send(1'b1, 1'b0, 1'b0, 10'h011, 16'hAB12, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 1});
    wait_rsp(1);
    w = '{9'h008, 1'b0, 1'b1, 8'h00, 8'h12};
    checks++;
    if (en_q.size() != 1 || en_q[0] !== w) begin
      errors++; $display("FAIL byte_store_lo got n=%0d %h want n=1 %h", en_q.size(), en_q[0], w);
    end
    en_q.delete();
    send(1'b1, 1'b0, 1'b0, 10'h010, 16'h347F, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 1});
    wait_rsp(2);
    w = '{9'h008, 1'b1, 1'b0, 8'h7F, 8'h00};
    checks++;
    if (en_q.size() != 1 || en_q[0] !== w) begin
      errors++; $display("FAIL byte_store_hi got n=%0d %h want n=1 %h", en_q.size(), en_q[0], w);
    end
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h7F12, 1'b0, acc + 2});
    send(1'b0, 1'b0, 1'b1, 10'h010, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h007F, 1'b0, acc + 2});
    send(1'b0, 1'b0, 1'b1, 10'h011, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h0012, 1'b0, acc + 2});
    wait_rsp(5);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL byte_store_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL byte_store_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_misalign();
    int acc;
    rsp_t e, a;
    acc_t w0, w1;
`ifdef LSU_MISALIGN_SPLIT_EN
    send(1'b1, 1'b1, 1'b0, 10'h3FE, 16'h1122, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 1});
    send(1'b1, 1'b1, 1'b0, 10'h000, 16'h3344, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 1});
    wait_rsp(2);
    en_q.delete();
    send(1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h2233, 1'b0, acc + 3});
    wait_rsp(3);
    w0 = '{9'h1FF, 1'b0, 1'b0, 8'h00, 8'h00};
    w1 = '{9'h000, 1'b0, 1'b0, 8'h00, 8'h00};
    checks++;
    if (en_q.size() != 2 || en_q[0] !== w0 || en_q[1] !== w1) begin
      errors++; $display("FAIL split_load_port got n=%0d %h %h want n=2 %h %h", en_q.size(), en_q[0], en_q[1], w0, w1);
    end
    en_q.delete();
    send(1'b1, 1'b1, 1'b0, 10'h3FF, 16'hA5C3, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b0, acc + 2});
    wait_rsp(4);
    w0 = '{9'h1FF, 1'b0, 1'b1, 8'h00, 8'hA5};
    w1 = '{9'h000, 1'b1, 1'b0, 8'hC3, 8'h00};
    checks++;
    if (en_q.size() != 2 || en_q[0] !== w0 || en_q[1] !== w1) begin
      errors++; $display("FAIL split_store_port got n=%0d %h %h want n=2 %h %h", en_q.size(), en_q[0], en_q[1], w0, w1);
    end
    send(1'b0, 1'b1, 1'b0, 10'h3FE, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h11A5, 1'b0, acc + 2});
    send(1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'hC344, 1'b0, acc + 2});
    wait_rsp(6);
`else
    send(1'b0, 1'b1, 1'b0, 10'h013, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b1, acc});
    send(1'b1, 1'b1, 1'b0, 10'h013, 16'hFFFF, 1'b0, acc);
    exp_q.push_back('{16'h0000, 1'b1, acc});
    wait_rsp(2);
    checks++;
    if (en_q.size() != 0) begin
      errors++; $display("FAIL misalign_no_access got n=%0d want n=0", en_q.size());
    end
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h7F12, 1'b0, acc + 2});
    wait_rsp(3);
    w0 = '{9'h008, 1'b0, 1'b0, 8'h00, 8'h00};
    w1 = w0;
    checks++;
    if (en_q.size() != 1 || en_q[0] !== w1) begin
      errors++; $display("FAIL misalign_next_port got n=%0d %h want n=1 %h", en_q.size(), en_q[0], w1);
    end
`endif
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL misalign_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL misalign_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_reset_mid();
    int acc;
    rsp_t e, a;
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, m_en, m_we_h, m_we_l, req_ready} !== 6'b0 || rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_wait_outputs got %b %h want 000000 0000",
                         {rsp_valid, rsp_err, m_en, m_we_h, m_we_l, req_ready}, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_wait_ready got %b want 1", req_ready); end
    // Abort a byte store while it sits in ISSUE: memory must keep 0x7F
    send(1'b1, 1'b0, 1'b0, 10'h010, 16'h0055, 1'b0, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (act_q.size() != 0) begin
      errors++; $display("FAIL reset_no_rsp got n=%0d want n=0", act_q.size());
    end
    act_q.delete(); en_q.delete();
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, acc);
    exp_q.push_back('{16'h7F12, 1'b0, acc + 2});
    wait_rsp(1);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL reset_fresh_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL reset_fresh_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    rsp_t e, a;
    send(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, acc1);
    exp_q.push_back('{16'h7F12, 1'b0, acc1 + 2});
    send(1'b0, 1'b0, 1'b1, 10'h011, 16'h0000, 1'b0, acc2);
    exp_q.push_back('{16'h0012, 1'b0, acc2 + 2});
    checks++;
    if (acc2 - acc1 != 4) begin
      errors++; $display("FAIL b2b_spacing got %0d want 4", acc2 - acc1);
    end
    wait_rsp(2);
    repeat (4) @(negedge clk);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL b2b_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", a.d, a.e, a.c, e.d, e.e, e.c);
      end
    end
    checks++;
    if (rsp_rdata !== 16'h0012 || rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_hold got d=%h e=%b v=%b want d=0012 e=0 v=0", rsp_rdata, rsp_err, rsp_valid);
    end
    exp_q.delete(); act_q.delete(); en_q.delete();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_load();
    test_byte_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
